housekeeping_adc_sequencer: RTL and testbench
=============================================

HOUSEKEEPING_ADC_SEQUENCER -- requirements
Module: housekeeping_adc_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 8, number of ADC channels scanned (1..16).
- TIMEOUT, 1024, maximum cycles spent waiting for one MISO byte.
- ADC_SEL, 3'b100, value driven on select_adc.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_core, in, 1, single clock.
- clk_core_resn, in, 1, reset, asynchronous, active-low.
- enable, in, 1, scan enable.
- ch_mask, in, NUM_CH, channels to convert.
- period, in, 24, idle cycles between scans.
- select_adc, out, 3, chip-select code to housekeeping SPI path.
- mosi_m_axis_tdata, out, 8, command byte.
- mosi_m_axis_tvalid, out, 1, command byte valid.
- mosi_m_axis_tlast, out, 1, last command byte.
- mosi_m_axis_tready, in, 1, command byte accepted.
- miso_s_axis_tdata, in, 8, returned byte.
- miso_s_axis_tvalid, in, 1, returned byte valid.
- miso_s_axis_tready, out, 1, returned byte accepted.
- sample_m_axis_tdata, out, 16, result: [15:12] channel, [11:0] sample.
- sample_m_axis_tuser, out, 1, 1 = timeout result.
- sample_m_axis_tvalid, out, 1, result valid.
- sample_m_axis_tready, in, 1, result accepted.
- busy, out, 1, scan in progress.
- timeout_count, out, 8, saturating count of timeouts.

Function
REQ-003 select_adc SHALL equal ADC_SEL at all times, including during reset.
REQ-004 The FSM SHALL have the states IDLE, SEND0, SEND1, WAIT_LO, WAIT_HI, EMIT.
REQ-005 In IDLE the period counter SHALL decrement to 0 and then hold at 0.
REQ-006 A scan SHALL start in the cycle after IDLE sees counter==0, enable=1 and ch_mask!=0.
- The scan begins at the lowest set mask bit.
- With ch_mask==0 the FSM stays in IDLE.
REQ-007 SEND0 SHALL drive tdata={ch[3:0],4'h0} with tlast=0.
REQ-008 SEND1 SHALL drive tdata=8'h00 with tlast=1.
REQ-009 Each state SHALL hold tdata/tlast stable with tvalid=1 until tvalid&&tready, then advance.
REQ-010 WAIT_LO SHALL capture the low byte and WAIT_HI the high byte, each on miso tvalid&&tready.
REQ-011 The sample SHALL be {hi[3:0],lo}; hi[7:4] SHALL be discarded.
REQ-012 miso_s_axis_tready SHALL be 1 in WAIT_LO, WAIT_HI and IDLE.
- Bytes accepted in IDLE are discarded (stale flush).
- miso_s_axis_tready SHALL be 0 in all other states.
REQ-013 Result latency: sample_m_axis_tvalid SHALL rise in the cycle after the high byte is accepted.
REQ-014 EMIT SHALL hold tdata/tuser stable until tready; backpressure stalls the scan with no loss.
REQ-015 After EMIT the FSM SHALL go to SEND0 of the next higher set mask bit.
- If there is none, or enable==0, it goes to IDLE and reloads the counter with period.
REQ-016 ch_mask SHALL be sampled once per channel step (at scan start and at each EMIT exit).
REQ-017 Deasserting enable mid-scan SHALL complete the current channel and then return to IDLE.
REQ-018 A wait counter SHALL clear on entry to each WAIT state.
- If it reaches TIMEOUT with no byte, the FSM goes to EMIT with tdata={ch,12'h000} and tuser=1.
- timeout_count increments and saturates at 8'hFF.
REQ-019 A byte arriving in the same cycle the counter reaches TIMEOUT SHALL be accepted; no timeout is raised.
REQ-020 With period==0, scans SHALL run back-to-back with one IDLE cycle between them.
REQ-021 busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 On clk_core_resn low, asynchronously:
- state=IDLE; period counter=0; wait counter=0.
- all tvalid=0, miso tready=0, busy=0, timeout_count=0, tdata/tuser/tlast=0.
REQ-023 Reset mid-scan SHALL abandon the transaction.
- Stale MISO bytes are flushed through REQ-012 after release.

Structure
REQ-024 housekeeping_pkg SHALL hold:
- the state enum;
- the default ADC_SEL constant;
- sample field positions (CH_MSB=15, CH_LSB=12, SAMPLE_W=12).
REQ-025 A single sub-module, hk_next_channel, SHALL be used: a combinational find-next-set-bit above an index, with a found flag.

Verification
REQ-026 mask=8'h05, period=10, ready=1, MISO replies lo=8'h34, hi=8'hF2 -> MOSI 8'h00,8'h00 then 8'h20,8'h00; samples 16'h0234, 16'h2234, tuser=0.
REQ-027 No MISO reply on ch1 with mask=8'h02 -> EMIT after 1024 wait cycles with tdata=16'h1000, tuser=1, timeout_count=1.
REQ-028 sample tready=0 for 50 cycles during a scan -> tdata held stable; no further MOSI bytes; scan resumes after ready.
REQ-029 Random mosi tready pattern -> no byte duplicated or dropped; tlast only on the second byte.
REQ-030 clk_core_resn pulsed in WAIT_HI, then one stray MISO byte -> byte flushed in IDLE; next scan samples correctly.
REQ-031 enable dropped during ch2 of mask 8'hFF -> ch2 result emitted, then IDLE; busy=0.

Source files
------------

// File: rtl/housekeeping_pkg.sv
// housekeeping_pkg: shared FSM state type, default chip-select and sample field layout
package housekeeping_pkg;
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, WAIT_LO, WAIT_HI, EMIT} state_e;
  localparam logic [2:0] ADC_SEL_DEF = 3'b100;
  localparam int CH_MSB   = 15;
  localparam int CH_LSB   = 12;
  localparam int SAMPLE_W = 12;
endpackage

// File: rtl/hk_next_channel.sv
// hk_next_channel: lowest set mask bit at or above start_i, with found flag
module hk_next_channel #(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [4:0]        start_i,
  output logic              found_o,
  output logic [3:0]        idx_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask_i[i] && 5'(i) >= start_i) begin
        found_o = 1'b1;
        idx_o   = 4'(i);
      end
  end
endmodule

// File: rtl/housekeeping_adc_sequencer.sv
// housekeeping_adc_sequencer: periodic multi-channel ADC scan over AXI-Stream SPI command/reply paths
module housekeeping_adc_sequencer
  import housekeeping_pkg::*;
#(
  parameter int          NUM_CH  = 8,
  parameter int          TIMEOUT = 1024,
  parameter logic [2:0]  ADC_SEL = ADC_SEL_DEF
) (
  input  logic              clk_core,
  input  logic              clk_core_resn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [23:0]       period,
  output logic [2:0]        select_adc,
  output logic [7:0]        mosi_m_axis_tdata,
  output logic              mosi_m_axis_tvalid,
  output logic              mosi_m_axis_tlast,
  input  logic              mosi_m_axis_tready,
  input  logic [7:0]        miso_s_axis_tdata,
  input  logic              miso_s_axis_tvalid,
  output logic              miso_s_axis_tready,
  output logic [15:0]       sample_m_axis_tdata,
  output logic              sample_m_axis_tuser,
  output logic              sample_m_axis_tvalid,
  input  logic              sample_m_axis_tready,
  output logic              busy,
  output logic [7:0]        timeout_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [23:0]   pcnt_q, pcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [3:0]    ch_q, ch_d;
  logic [7:0]    lo_q, lo_d, tcnt_q, tcnt_d;
  logic [15:0]   smp_q, smp_d;
  logic          tuser_q, tuser_d;
  logic          nxt_found, wait_to;
  logic [3:0]    nxt_idx;
  // From IDLE search from bit 0; from EMIT search strictly above the current channel
  hk_next_channel #(.NUM_CH(NUM_CH)) u_next (
    .mask_i  (ch_mask),
    .start_i (state_q == IDLE ? 5'd0 : 5'(ch_q) + 5'd1),
    .found_o (nxt_found),
    .idx_o   (nxt_idx)
  );
  assign wait_to = wcnt_q == WW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    ch_d    = ch_q;
    lo_d    = lo_q;
    tcnt_d  = tcnt_q;
    smp_d   = smp_q;
    tuser_d = tuser_q;
    case (state_q)
      IDLE:
        if (pcnt_q != '0) pcnt_d = pcnt_q - 24'd1;
        else if (enable && nxt_found) begin
          state_d = SEND0;
          ch_d    = nxt_idx;
        end
      SEND0: if (mosi_m_axis_tready) state_d = SEND1;
      SEND1:
        if (mosi_m_axis_tready) begin
          state_d = WAIT_LO;
          wcnt_d  = '0;
        end
      WAIT_LO, WAIT_HI:
        if (miso_s_axis_tvalid && state_q == WAIT_LO) begin
          lo_d    = miso_s_axis_tdata;
          wcnt_d  = '0;
          state_d = WAIT_HI;
        end else if (miso_s_axis_tvalid || wait_to) begin
          // A byte landing on the final wait cycle wins over the timeout
          smp_d[CH_MSB:CH_LSB]  = ch_q;
          smp_d[SAMPLE_W-1:0]   = miso_s_axis_tvalid ? {miso_s_axis_tdata[3:0], lo_q} : '0;
          tuser_d               = !miso_s_axis_tvalid;
          tcnt_d                = tcnt_q + 8'(!miso_s_axis_tvalid && tcnt_q != 8'hFF);
          state_d               = EMIT;
        end else wcnt_d = wcnt_q + WW'(1);
      EMIT:
        if (sample_m_axis_tready) begin
          state_d = enable && nxt_found ? SEND0 : IDLE;
          ch_d    = enable && nxt_found ? nxt_idx : ch_q;
          pcnt_d  = enable && nxt_found ? pcnt_q : period;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_core or negedge clk_core_resn)
    if (!clk_core_resn) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
      ch_q    <= '0;
      lo_q    <= '0;
      tcnt_q  <= '0;
      smp_q   <= '0;
      tuser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      wcnt_q  <= wcnt_d;
      ch_q    <= ch_d;
      lo_q    <= lo_d;
      tcnt_q  <= tcnt_d;
      smp_q   <= smp_d;
      tuser_q <= tuser_d;
    end
  assign select_adc           = ADC_SEL;
  assign mosi_m_axis_tdata    = state_q == SEND0 ? {ch_q, 4'h0} : 8'h00;
  assign mosi_m_axis_tvalid   = state_q == SEND0 || state_q == SEND1;
  assign mosi_m_axis_tlast    = state_q == SEND1;
  // IDLE keeps accepting so stale replies are flushed, but never while held in reset
  assign miso_s_axis_tready   = clk_core_resn && (state_q inside {IDLE, WAIT_LO, WAIT_HI});
  assign sample_m_axis_tdata  = smp_q;
  assign sample_m_axis_tuser  = tuser_q;
  assign sample_m_axis_tvalid = state_q == EMIT;
  assign busy                 = state_q != IDLE;
  assign timeout_count        = tcnt_q;
endmodule

// File: tb/tb_housekeeping_adc_sequencer.sv
// tb_housekeeping_adc_sequencer: randomized scans checked against a per-channel transaction model
module tb_housekeeping_adc_sequencer;
  localparam int TO = 1024;
  logic        clk_core = 1'b0, clk_core_resn = 1'b0, enable = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [23:0] period = '0;
  logic [2:0]  select_adc;
  logic [7:0]  mosi_m_axis_tdata, miso_s_axis_tdata = '0, timeout_count;
  logic        mosi_m_axis_tvalid, mosi_m_axis_tlast, mosi_m_axis_tready = 1'b0;
  logic        miso_s_axis_tvalid = 1'b0, miso_s_axis_tready;
  logic [15:0] sample_m_axis_tdata;
  logic        sample_m_axis_tuser, sample_m_axis_tvalid, sample_m_axis_tready = 1'b0, busy;
  int          n_chk = 0, n_fail = 0, mosi_hs = 0, exp_hs = 0, prev_p;
  logic [7:0]  lo, hi;

  housekeeping_adc_sequencer #(.NUM_CH(8), .TIMEOUT(TO)) dut (
    .clk_core(clk_core), .clk_core_resn(clk_core_resn), .enable(enable), .ch_mask(ch_mask),
    .period(period), .select_adc(select_adc),
    .mosi_m_axis_tdata(mosi_m_axis_tdata), .mosi_m_axis_tvalid(mosi_m_axis_tvalid),
    .mosi_m_axis_tlast(mosi_m_axis_tlast), .mosi_m_axis_tready(mosi_m_axis_tready),
    .miso_s_axis_tdata(miso_s_axis_tdata), .miso_s_axis_tvalid(miso_s_axis_tvalid),
    .miso_s_axis_tready(miso_s_axis_tready),
    .sample_m_axis_tdata(sample_m_axis_tdata), .sample_m_axis_tuser(sample_m_axis_tuser),
    .sample_m_axis_tvalid(sample_m_axis_tvalid), .sample_m_axis_tready(sample_m_axis_tready),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) if (mosi_m_axis_tvalid && mosi_m_axis_tready) mosi_hs <= mosi_hs + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic mosi_byte(input logic [7:0] d, input logic l);
    int n = 0;
    exp_hs++;
    mosi_m_axis_tready = 1'($urandom_range(0, 1));
    while (!(mosi_m_axis_tvalid && mosi_m_axis_tready)) begin
      if (n == 300) begin
        chk("mosi_valid", mosi_m_axis_tvalid, 1);
        return;
      end
      @(negedge clk_core);
      n++;
      mosi_m_axis_tready = 1'($urandom_range(0, 1));
    end
    chk("mosi_data", mosi_m_axis_tdata, d);
    chk("mosi_last", mosi_m_axis_tlast, l);
    @(negedge clk_core);
    mosi_m_axis_tready = 1'b0;
  endtask

  task automatic miso_send(input logic [7:0] b, input int d);
    repeat (d) @(negedge clk_core);
    miso_s_axis_tvalid = 1'b1;
    miso_s_axis_tdata  = b;
    chk("miso_ready", miso_s_axis_tready, 1);
    @(negedge clk_core);
    miso_s_axis_tvalid = 1'b0;
  endtask

  task automatic sample_take(input logic [15:0] e, input logic u, input bit lat, input int stall);
    int n = 0, hs0;
    bit held = 1'b1;
    if (lat) chk("smp_latency", sample_m_axis_tvalid, 1);
    while (!sample_m_axis_tvalid && n < 2000) begin
      @(negedge clk_core);
      n++;
    end
    chk("smp_valid", sample_m_axis_tvalid, 1);
    hs0 = mosi_hs;
    repeat (stall) begin
      held &= (sample_m_axis_tdata === e) && sample_m_axis_tvalid;
      @(negedge clk_core);
    end
    if (stall > 0) begin
      chk("smp_hold", held, 1);
      chk("mosi_quiet", mosi_hs, hs0);
    end
    sample_m_axis_tready = 1'b1;
    chk("smp_data", sample_m_axis_tdata, e);
    chk("smp_user", sample_m_axis_tuser, u);
    @(negedge clk_core);
    sample_m_axis_tready = 1'b0;
  endtask

  task automatic wait_to();
    int n = 0;
    while (!sample_m_axis_tvalid && n < 2000) begin
      @(negedge clk_core);
      n++;
    end
    chk("to_cycles", n, TO);
  endtask

  task automatic idle_gap(input int e);
    int n = 0;
    while (!busy && n < 200) begin
      @(negedge clk_core);
      n++;
    end
    chk("idle_gap", n, e);
  endtask

  task automatic run_channel(input logic [3:0] ch, input logic [7:0] l, input logic [7:0] h, input int stall);
    mosi_byte({ch, 4'h0}, 1'b0);
    mosi_byte(8'h00, 1'b1);
    miso_send(l, $urandom_range(0, 4));
    miso_send(h, $urandom_range(0, 4));
    sample_take({ch, h[3:0], l}, 1'b0, 1'b1, stall);
  endtask

  task automatic run_scan(input logic [7:0] m);
    for (int c = 0; c < 8; c++)
      if (m[c]) run_channel(4'(c), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
  endtask

  initial begin
    repeat (3) @(negedge clk_core);
    chk("rst_sel", select_adc, 3'b100);
    chk("rst_mosi_valid", mosi_m_axis_tvalid, 0);
    chk("rst_mosi_last", mosi_m_axis_tlast, 0);
    chk("rst_mosi_data", mosi_m_axis_tdata, 0);
    chk("rst_miso_ready", miso_s_axis_tready, 0);
    chk("rst_smp_valid", sample_m_axis_tvalid, 0);
    chk("rst_smp_data", sample_m_axis_tdata, 0);
    chk("rst_smp_user", sample_m_axis_tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcnt", timeout_count, 0);
    clk_core_resn = 1'b1;
    @(negedge clk_core);
    chk("idle_miso_ready", miso_s_axis_tready, 1);
    ch_mask = 8'h05;
    period  = 24'd10;
    enable  = 1'b1;
    run_channel(4'd0, 8'h34, 8'hF2, 0);
    run_channel(4'd2, 8'h34, 8'hF2, 0);
    chk("scan_done_busy", busy, 0);
    prev_p = 10;
    for (int i = 0; i < 8; i++) begin
      ch_mask = 8'($urandom_range(1, 255));
      period  = i == 2 ? 24'd0 : 24'($urandom_range(0, 6));
      idle_gap(prev_p + 1);
      run_scan(ch_mask);
      prev_p = int'(period);
    end
    ch_mask = 8'h00;
    repeat (40) @(negedge clk_core);
    chk("mask0_busy", busy, 0);
    chk("sel_const", select_adc, 3'b100);
    period  = 24'd0;
    ch_mask = 8'h02;
    mosi_byte(8'h10, 1'b0);
    mosi_byte(8'h00, 1'b1);
    wait_to();
    sample_take(16'h1000, 1'b1, 1'b0, 0);
    chk("tcnt_1", timeout_count, 1);
    idle_gap(1);
    lo = 8'($urandom);
    hi = 8'($urandom);
    mosi_byte(8'h10, 1'b0);
    mosi_byte(8'h00, 1'b1);
    miso_send(lo, TO - 1);
    miso_send(hi, 0);
    sample_take({4'd1, hi[3:0], lo}, 1'b0, 1'b1, 0);
    chk("tcnt_edge", timeout_count, 1);
    idle_gap(1);
    mosi_byte(8'h10, 1'b0);
    mosi_byte(8'h00, 1'b1);
    miso_send(8'($urandom), 0);
    wait_to();
    sample_take(16'h1000, 1'b1, 1'b0, 0);
    chk("tcnt_2", timeout_count, 2);
    ch_mask = 8'h03;
    idle_gap(1);
    run_channel(4'd0, 8'($urandom), 8'($urandom), 50);
    run_channel(4'd1, 8'($urandom), 8'($urandom), 0);
    ch_mask = 8'h01;
    idle_gap(1);
    mosi_byte(8'h00, 1'b0);
    mosi_byte(8'h00, 1'b1);
    miso_send(8'($urandom), 0);
    clk_core_resn = 1'b0;
    enable = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_miso_ready", miso_s_axis_tready, 0);
    chk("midrst_tcnt", timeout_count, 0);
    @(negedge clk_core);
    clk_core_resn = 1'b1;
    @(negedge clk_core);
    miso_send(8'hAA, 0);
    chk("stray_busy", busy, 0);
    enable = 1'b1;
    run_channel(4'd0, 8'($urandom), 8'($urandom), 0);
    ch_mask = 8'hFF;
    idle_gap(1);
    run_channel(4'd0, 8'($urandom), 8'($urandom), 0);
    run_channel(4'd1, 8'($urandom), 8'($urandom), 0);
    lo = 8'($urandom);
    hi = 8'($urandom);
    mosi_byte(8'h20, 1'b0);
    enable = 1'b0;
    mosi_byte(8'h00, 1'b1);
    miso_send(lo, 1);
    miso_send(hi, 2);
    sample_take({4'd2, hi[3:0], lo}, 1'b0, 1'b1, 0);
    chk("endis_busy", busy, 0);
    prev_p = mosi_hs;
    repeat (20) @(negedge clk_core);
    chk("endis_quiet", mosi_hs, prev_p);
    chk("endis_busy_hold", busy, 0);
    chk("mosi_total", mosi_hs, exp_hs);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
